// File: rtl/coef_rom_arbiter.sv
// coef_rom_arbiter: round-robin burst arbiter sharing one synchronous coefficient ROM between two requesters
module coef_rom_arbiter #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] base0,
  input  logic [AW-1:0] base1,
  input  logic [AW-1:0] stride0,
  input  logic [AW-1:0] stride1,
  input  logic [AW:0]   len0,
  input  logic [AW:0]   len1,
  input  logic [DW-1:0] rom_dout,
  output logic          ack0,
  output logic          ack1,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  output logic [DW-1:0] coef,
  output logic          coef_valid,
  output logic          coef_id,
  output logic [AW-1:0] coef_idx,
  output logic          coef_last,
  output logic          busy
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_d;
  logic last_grant, iss_id, iss_last, v1, id1, last1;
  logic [AW-1:0] addr, stride, rem, iss_idx, idx1;
  logic r0, r1, grant, gid, more, en_d, busy_d;
  logic [AW-1:0] g_base, g_stride;
  logic [AW:0] g_len;
  always_comb begin
    r0 = req0 & ~ack0;
    r1 = req1 & ~ack1;
    grant = (state == IDLE) & (r0 | r1);
    gid = (r0 & r1) ? ~last_grant : r1;
    g_base = gid ? base1 : base0;
    g_stride = gid ? stride1 : stride0;
    g_len = gid ? len1 : len0;
    more = (state == BURST) & (rem != '0);
    en_d = (grant & (g_len != '0)) | more;
    state_d = en_d ? BURST : IDLE;
    busy_d = en_d | rom_en | v1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rom_en <= 1'b0;
      rom_addr <= '0;
      addr <= '0;
      stride <= '0;
      rem <= '0;
      iss_id <= 1'b0;
      iss_idx <= '0;
      iss_last <= 1'b0;
      v1 <= 1'b0;
      id1 <= 1'b0;
      idx1 <= '0;
      last1 <= 1'b0;
      coef <= '0;
      coef_valid <= 1'b0;
      coef_id <= 1'b0;
      coef_idx <= '0;
      coef_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      ack0 <= grant & ~gid;
      ack1 <= grant & gid;
      rom_en <= en_d;
      busy <= busy_d;
      if (grant) begin
        last_grant <= gid;
        iss_id <= gid;
        stride <= g_stride;
        rom_addr <= g_base;
        addr <= g_base + g_stride;
        rem <= AW'(g_len - 1'b1);
        iss_idx <= '0;
        iss_last <= g_len == {{AW{1'b0}}, 1'b1};
      end else if (more) begin
        rom_addr <= addr;
        addr <= addr + stride;
        rem <= rem - AW'(1);
        iss_idx <= iss_idx + AW'(1);
        iss_last <= rem == AW'(1);
      end
      // the ROM answers one cycle after rom_en, so coef is captured one stage later
      v1 <= rom_en;
      id1 <= iss_id;
      idx1 <= iss_idx;
      last1 <= rom_en & iss_last;
      coef_valid <= v1;
      coef_id <= id1;
      coef_idx <= idx1;
      coef_last <= v1 & last1;
      if (v1) coef <= rom_dout;
    end
  end
endmodule

// File: tb/tb_coef_rom_arbiter.sv
// tb_coef_rom_arbiter: directed and randomized bursts checked against a cycle-timeline model of the arbiter
module tb_coef_rom_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] base0 = '0, base1 = '0, stride0 = '0, stride1 = '0;
  logic [AW:0] len0 = '0, len1 = '0;
  logic [DW-1:0] rom_dout;
  logic ack0, ack1, rom_en, coef_valid, coef_id, coef_last, busy;
  logic [AW-1:0] rom_addr, coef_idx;
  logic [DW-1:0] coef;
  logic [DW-1:0] rom [32];
  int n_chk = 0;
  int n_fail = 0;

  coef_rom_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .base0(base0), .base1(base1), .stride0(stride0), .stride1(stride1),
    .len0(len0), .len1(len1), .rom_dout(rom_dout),
    .ack0(ack0), .ack1(ack1), .rom_en(rom_en), .rom_addr(rom_addr),
    .coef(coef), .coef_valid(coef_valid), .coef_id(coef_id),
    .coef_idx(coef_idx), .coef_last(coef_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_coef"}, coef, 0);
    chk({tag, "_coef_valid"}, coef_valid, 0);
    chk({tag, "_coef_id"}, coef_id, 0);
    chk({tag, "_coef_idx"}, coef_idx, 0);
    chk({tag, "_coef_last"}, coef_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  function automatic int addr_of(input int base, input int stride, input int k);
    return (base + k * stride) % 32;
  endfunction

  task automatic set_req(input int id, input int b, input int s, input int l, input logic v);
    if (id == 0) begin
      base0 = AW'(b); stride0 = AW'(s); len0 = (AW+1)'(l); req0 = v;
    end else begin
      base1 = AW'(b); stride1 = AW'(s); len1 = (AW+1)'(l); req1 = v;
    end
  endtask

  // cycle c=0 is the ack cycle; reads issue on c<len, data returns on c-2
  task automatic run_single(input int id, input int base, input int stride, input int len, input int ncyc);
    set_req(id, base, stride, len, 1'b1);
    for (int c = 0; c < ncyc; c++) begin
      int k;
      logic ev;
      @(negedge clk);
      k = c - 2;
      ev = (c >= 2) && (c < len + 2);
      chk("ack0", ack0, (c == 0) && (id == 0));
      chk("ack1", ack1, (c == 0) && (id == 1));
      chk("rom_en", rom_en, c < len);
      if (c < len) chk("rom_addr", rom_addr, addr_of(base, stride, c));
      chk("coef_valid", coef_valid, ev);
      if (ev) begin
        chk("coef", coef, rom[addr_of(base, stride, k)]);
        chk("coef_id", coef_id, id);
        chk("coef_idx", coef_idx, k);
        chk("coef_last", coef_last, k == len - 1);
      end
      chk("busy", busy, (len > 0) && (c < len + 2));
      if (c == 0) set_req(id, base, stride, len, 1'b0);
    end
  endtask

  initial begin
    int b0, s0, b1, s1, n0, n1;
    for (int i = 0; i < 32; i++) rom[i] = DW'(i * 1237 + 17);
    rom[0] = 16'h7fff; rom[1] = 16'hca17; rom[2] = 16'hbfb6; rom[3] = 16'h4f4f;
    rom[4] = 16'hf5bf; rom[5] = 16'h0090; rom[6] = 16'h002e; rom[7] = 16'h0009;
    rom[8] = 16'h0001; rom[30] = 16'h0000;

    b0 = $urandom_range(31); s0 = $urandom_range(31);
    b1 = $urandom_range(31); s1 = $urandom_range(31);
    set_req(0, b0, s0, 2, 1'b1);
    set_req(1, b1, s1, 2, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset");
    end
    rst = 1'b0;
    n0 = 0; n1 = 0;
    // both held from reset release: grants alternate 0,1,0,1 every len+1 cycles
    for (int c = 0; c < 14; c++) begin
      int g, k, id;
      logic ea, ev;
      @(negedge clk);
      g = c / 3;
      ea = (c % 3 == 0) && (c < 12);
      chk("rr_ack0", ack0, ea && (g % 2 == 0));
      chk("rr_ack1", ack1, ea && (g % 2 == 1));
      chk("rr_rom_en", rom_en, (c < 11) && (c % 3 != 2));
      if ((c < 11) && (c % 3 != 2))
        chk("rr_rom_addr", rom_addr, (g % 2 == 0) ? addr_of(b0, s0, c % 3) : addr_of(b1, s1, c % 3));
      ev = (c >= 2) && (c <= 12) && ((c - 2) % 3 != 2);
      chk("rr_coef_valid", coef_valid, ev);
      if (ev) begin
        k = (c - 2) % 3;
        id = ((c - 2) / 3) % 2;
        chk("rr_coef", coef, rom[(id == 0) ? addr_of(b0, s0, k) : addr_of(b1, s1, k)]);
        chk("rr_coef_id", coef_id, id);
        chk("rr_coef_idx", coef_idx, k);
        chk("rr_coef_last", coef_last, k == 1);
      end
      chk("rr_busy", busy, c < 13);
      if (ack0) begin req0 = 1'b0; n0++; end
      else if (!req0 && n0 < 2) req0 = 1'b1;
      if (ack1) begin req1 = 1'b0; n1++; end
      else if (!req1 && n1 < 2) req1 = 1'b1;
    end

    run_single(0, 0, 1, 9, 12);
    run_single(1, 30, 3, 4, 7);

    set_req(0, $urandom_range(31), $urandom_range(31), 0, 1'b1);
    @(negedge clk);
    chk("len0_ack0", ack0, 1);
    chk("len0_rom_en", rom_en, 0);
    chk("len0_busy", busy, 0);
    @(negedge clk);
    chk("len0_ack0_held_req", ack0, 0);
    chk("len0_rom_en2", rom_en, 0);
    chk("len0_coef_valid", coef_valid, 0);
    req0 = 1'b0;
    @(negedge clk);
    chk("len0_ack0_after", ack0, 0);

    set_req(0, $urandom_range(31), $urandom_range(31), 0, 1'b1);
    @(negedge clk);
    chk("len0b_ack0", ack0, 1);
    chk("len0b_rom_en", rom_en, 0);
    chk("len0b_coef_valid", coef_valid, 0);
    req0 = 1'b0;
    run_single(1, $urandom_range(31), $urandom_range(31), 3, 6);

    run_single(0, 5, 1, 32, 35);

    repeat (8) begin
      int l;
      l = $urandom_range(12);
      run_single($urandom_range(1), $urandom_range(31), $urandom_range(31), l, l + 3);
    end

    run_single(0, 0, 1, 9, 5);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    repeat (2) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_coef_valid", coef_valid, 0);
      chk("post_rst_rom_en", rom_en, 0);
    end
    run_single(1, 2, $urandom_range(31), 1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
